// File: rtl/interval_scheduler_pkg.sv
// Shared types and constants for the interval scheduler: FSM states,
// the min/max result record, watchdog limit and timeout sentinel values.
package interval_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        WAIT_RES = 2'd2,
        DONE     = 2'd3
    } state_t;

    // Result record as seen by the FIFO; the index is narrowed to IDX_W
    // by the top before storage.
    typedef struct packed {
        logic [31:0]        index;
        logic signed [15:0] min_val;
        logic signed [15:0] max_val;
    } result_t;

    localparam int unsigned      WD_LIMIT     = 1024;
    localparam logic signed [15:0] SENTINEL_MIN = 16'sh7FFF;
    localparam logic signed [15:0] SENTINEL_MAX = 16'sh8000;

    // A programmed length of 0 selects the build-time default.
    function automatic logic [31:0] resolve_len(input logic [31:0] cfg, input logic [31:0] dflt);
        return (cfg == 32'd0) ? dflt : cfg;
    endfunction

endpackage

// File: rtl/interval_scheduler_result_fifo.sv
// First-word-fall-through result FIFO. A push into a full FIFO only
// succeeds when a pop happens in the same cycle; pops on empty are ignored.
module result_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 40
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rd_ptr_q];

    // Pointer and occupancy update; pointers wrap naturally (DEPTH is a power of two).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer/occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage, one register per entry so the head reads zero after reset.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                mem_q[gi] <= '0;
            else if (do_push && (wr_ptr_q == AW'(gi)))
                mem_q[gi] <= wdata;
        end
    end

endmodule

// File: rtl/interval_scheduler.sv
// Interval scheduler: gates samples to the min/max datapath, marks the end
// of each interval, collects results into a FWFT FIFO.
// Optional macro INTERVAL_SCHED_WATCHDOG_EN adds a WAIT_RES watchdog that
// pushes a sentinel result and raises wd_timeout.
module interval_scheduler
    import interval_pkg::*;
#(
    parameter int INTERVAL_LEN  = 44100,
    parameter int NUM_INTERVALS = 10,
    parameter int FIFO_DEPTH    = 16,
    parameter int IDX_W         = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [31:0]             cfg_len,
    input  logic                    sample_valid,
    output logic                    mm_valid,
    output logic                    mm_interval_done,
    input  logic signed [15:0]      mm_min,
    input  logic signed [15:0]      mm_max,
    input  logic                    mm_ready,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [IDX_W-1:0]        res_index,
    output logic signed [15:0]      res_min,
    output logic signed [15:0]      res_max,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow,
    output logic [15:0]             dropped
`ifdef INTERVAL_SCHED_WATCHDOG_EN
    ,
    output logic                    wd_timeout
`endif
);
    localparam int FW = IDX_W + 32;

    state_t      state_q, state_d;
    logic [31:0] len_q, len_d;
    logic [31:0] sample_cnt_q, sample_cnt_d;
    logic [31:0] interval_cnt_q, interval_cnt_d;
    logic [15:0] dropped_q, dropped_d;
    logic        overflow_q, overflow_d;
    logic        is_last, wd_fire, push;
    result_t     push_rec;
    logic [FW-1:0] fifo_rdata;
    logic        fifo_full, fifo_empty;

`ifdef INTERVAL_SCHED_WATCHDOG_EN
    logic [15:0] wd_cnt_q, wd_cnt_d;
    logic        wd_timeout_q, wd_timeout_d;
    assign wd_fire    = (state_q == WAIT_RES) && !mm_ready && (wd_cnt_q == 16'(WD_LIMIT - 1));
    assign wd_timeout = wd_timeout_q;
`else
    assign wd_fire = 1'b0;
`endif

    assign is_last = (sample_cnt_q == len_q - 32'd1);

    // Next-state, counters, result push and overflow tracking.
    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        sample_cnt_d   = sample_cnt_q;
        interval_cnt_d = interval_cnt_q;
        dropped_d      = dropped_q;
        overflow_d     = overflow_q;
        push           = 1'b0;
        push_rec       = '0;
`ifdef INTERVAL_SCHED_WATCHDOG_EN
        wd_cnt_d       = '0;
        wd_timeout_d   = wd_timeout_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d        = RUN;
                    len_d          = resolve_len(cfg_len, 32'(INTERVAL_LEN));
                    sample_cnt_d   = '0;
                    interval_cnt_d = '0;
                    dropped_d      = '0;
                    overflow_d     = 1'b0;
`ifdef INTERVAL_SCHED_WATCHDOG_EN
                    wd_timeout_d   = 1'b0;
`endif
                end
            end
            RUN: begin
                if (sample_valid) begin
                    if (is_last) begin
                        sample_cnt_d = '0;
                        state_d      = WAIT_RES;
                    end else begin
                        sample_cnt_d = sample_cnt_q + 32'd1;
                    end
                end
            end
            WAIT_RES: begin
                if (sample_valid && dropped_q != 16'hFFFF)
                    dropped_d = dropped_q + 16'd1;
`ifdef INTERVAL_SCHED_WATCHDOG_EN
                wd_cnt_d = mm_ready ? 16'd0 : wd_cnt_q + 16'd1;
                if (wd_fire) wd_timeout_d = 1'b1;
`endif
                if (mm_ready || wd_fire) begin
                    push             = 1'b1;
                    push_rec.index   = interval_cnt_q;
                    push_rec.min_val = wd_fire ? SENTINEL_MIN : mm_min;
                    push_rec.max_val = wd_fire ? SENTINEL_MAX : mm_max;
                    interval_cnt_d   = interval_cnt_q + 32'd1;
                    state_d          = (interval_cnt_d == 32'(NUM_INTERVALS)) ? DONE : RUN;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort wins over everything: drop the pending result, keep the FIFO.
        if (abort) begin
            state_d        = IDLE;
            sample_cnt_d   = '0;
            interval_cnt_d = '0;
            dropped_d      = '0;
            push           = 1'b0;
`ifdef INTERVAL_SCHED_WATCHDOG_EN
            wd_cnt_d       = '0;
            wd_timeout_d   = wd_timeout_q;
`endif
        end

        if (push && fifo_full && !res_ready)
            overflow_d = 1'b1;
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            len_q          <= '0;
            sample_cnt_q   <= '0;
            interval_cnt_q <= '0;
            dropped_q      <= '0;
            overflow_q     <= 1'b0;
`ifdef INTERVAL_SCHED_WATCHDOG_EN
            wd_cnt_q       <= '0;
            wd_timeout_q   <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            sample_cnt_q   <= sample_cnt_d;
            interval_cnt_q <= interval_cnt_d;
            dropped_q      <= dropped_d;
            overflow_q     <= overflow_d;
`ifdef INTERVAL_SCHED_WATCHDOG_EN
            wd_cnt_q       <= wd_cnt_d;
            wd_timeout_q   <= wd_timeout_d;
`endif
        end
    end

    result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({push_rec.index[IDX_W-1:0], push_rec.min_val, push_rec.max_val}),
        .pop   (res_ready),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign mm_valid         = (state_q == RUN) && sample_valid;
    assign mm_interval_done = (state_q == RUN) && is_last;
    assign busy             = (state_q == RUN) || (state_q == WAIT_RES);
    assign done             = (state_q == DONE);
    assign overflow         = overflow_q;
    assign dropped          = dropped_q;
    assign res_valid        = !fifo_empty;
    assign res_index        = fifo_rdata[FW-1:32];
    assign res_min          = fifo_rdata[31:16];
    assign res_max          = fifo_rdata[15:0];

endmodule

// File: tb/tb_interval_scheduler.sv
// Scoreboard bench for interval_scheduler (3 intervals, 2-entry FIFO).
module tb_interval_scheduler;
    localparam int NUM = 3;
    localparam int FD  = 2;
    localparam int IW  = 8;

    logic clk = 1'b0;
    logic rst, start, abort, sample_valid, mm_ready, res_ready;
    logic [31:0] cfg_len;
    logic signed [15:0] mm_min, mm_max;
    logic mm_valid, mm_interval_done, res_valid, busy, done, overflow;
    logic [IW-1:0] res_index;
    logic signed [15:0] res_min, res_max;
    logic [15:0] dropped;
`ifdef INTERVAL_SCHED_WATCHDOG_EN
    logic wd_timeout;
`endif

    typedef struct packed {
        logic [IW-1:0]      idx;
        logic signed [15:0] mn;
        logic signed [15:0] mx;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   ovf_exp  = 0;

    always #5 clk = ~clk;

    interval_scheduler #(
        .INTERVAL_LEN (44100),
        .NUM_INTERVALS(NUM),
        .FIFO_DEPTH   (FD),
        .IDX_W        (IW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_len(cfg_len),
        .sample_valid(sample_valid), .mm_valid(mm_valid), .mm_interval_done(mm_interval_done),
        .mm_min(mm_min), .mm_max(mm_max), .mm_ready(mm_ready),
        .res_valid(res_valid), .res_ready(res_ready), .res_index(res_index),
        .res_min(res_min), .res_max(res_max), .busy(busy), .done(done),
        .overflow(overflow), .dropped(dropped)
`ifdef INTERVAL_SCHED_WATCHDOG_EN
        , .wd_timeout(wd_timeout)
`endif
    );

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Compare/pop the head if the consumer pops this cycle, then model a push.
    task automatic sb_step(input bit push_exp, input exp_t rec);
        exp_t e;
        check("res_valid", res_valid, sb_q.size() > 0);
        if (res_valid && res_ready) begin
            if (sb_q.size() == 0) begin
                check("pop_unexpected", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("res_index", res_index, e.idx);
                check("res_min", res_min, e.mn);
                check("res_max", res_max, e.mx);
                $display("pop idx=%0d min=%0d max=%0d", res_index, res_min, res_max);
            end
        end
        if (push_exp) begin
            if (sb_q.size() < FD) sb_q.push_back(rec);
            else ovf_exp = 1;
        end
    endtask

    task automatic idle_cycles(input int n, input logic rr);
        exp_t none = '0;
        for (int i = 0; i < n; i++) begin
            sample_valid = 0; mm_ready = 0; abort = 0; start = 0; res_ready = rr;
            #2;
            sb_step(0, none);
            @(posedge clk); #1;
        end
        res_ready = 0;
    endtask

    // rr_mode: 0 never pop, 1 always pop, 2 pop only in push cycles.
    // abort_at: push number replaced by abort (+mm_ready same cycle), -1 none.
    task automatic run(input logic [31:0] cfg, input int len, input int delay,
                       input int rr_mode, input bit sv_rand, input int abort_at);
        int n = 0, ivl = 0, pushes = 0, cd = 0, cyc = 0, exp_drop = 0;
        int bound;
        bit waiting, push, ab = 0;
        exp_t rec = '0;
        bound = len * NUM * 3 + 200;
        cfg_len = cfg; start = 1; sample_valid = 0; mm_ready = 0; abort = 0;
        res_ready = (rr_mode == 1);
        #2;
        sb_step(0, rec);
        @(posedge clk); #1;
        start = 0; ovf_exp = 0;
        while (pushes < NUM && !ab && cyc < bound) begin
            cyc++;
            waiting = (cd > 0);
            push = 0; mm_ready = 0; abort = 0;
            sample_valid = sv_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    mm_ready = 1;
                    mm_min = 16'($urandom);
                    mm_max = 16'($urandom);
                    rec = {8'(pushes), mm_min, mm_max};
                    if (pushes == abort_at) begin
                        abort = 1; ab = 1;
                    end else begin
                        push = 1; pushes++;
                    end
                end
            end
            res_ready = (rr_mode == 1) || (rr_mode == 2 && push);
            #2;
            check("mm_valid", mm_valid, sample_valid && !waiting);
            if (!waiting && len == 1) check("ivl_done_len1", mm_interval_done, 1);
            if (waiting && sample_valid) exp_drop++;
            if (!waiting && sample_valid) begin
                n++;
                if (mm_interval_done) begin
                    check("ivl_end", n, (ivl + 1) * len);
                    $display("interval %0d ends at sample %0d", ivl, n);
                    ivl++;
                    cd = delay;
                end
            end
            if (push) $display("push idx=%0d min=%0d max=%0d", rec.idx, rec.mn, rec.mx);
            sb_step(push, rec);
            @(posedge clk); #1;
        end
        abort = 0; mm_ready = 0; sample_valid = 0; res_ready = 0;
        check("run_in_budget", cyc < bound, 1);
        #2;
        check("done", done, !ab);
        check("busy", busy, 0);
        check("dropped", dropped, ab ? 0 : exp_drop);
        check("overflow", overflow, ovf_exp);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1; start = 0; abort = 0; cfg_len = 0; sample_valid = 1;
        mm_ready = 0; mm_min = 0; mm_max = 0; res_ready = 0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_overflow", overflow, 0);
        check("rst_dropped", dropped, 0);
        check("rst_mm_valid", mm_valid, 0);
        check("rst_mm_ivl_done", mm_interval_done, 0);
        @(posedge clk); #1;
        rst = 0; sample_valid = 0;
        idle_cycles(2, 0);

        // Basic run: len 4, continuous samples, result 2 cycles after done.
        run(32'd4, 4, 2, 1, 0, -1);
        check("dropped_total", dropped, 6);
        idle_cycles(3, 1);

        // len 1, random sample gaps.
        run(32'd1, 1, 1, 1, 1, -1);
        idle_cycles(3, 1);

        // Overflow: nobody pops, third result lost.
        run(32'd4, 4, 3, 0, 1, -1);
        check("fifo_held", res_valid, 1);
        // Push while full with a simultaneous pop: no overflow.
        run(32'd4, 4, 2, 2, 0, -1);
        idle_cycles(4, 1);

        // Abort in WAIT_RES with mm_ready in the same cycle.
        run(32'd4, 4, 2, 0, 0, 1);
        check("abort_fifo_kept", res_valid, 1);
        mm_ready = 1; #2; sb_step(0, '0); @(posedge clk); #1; mm_ready = 0;
        idle_cycles(3, 1);
        check("idle_ready_ignored", res_valid, 0);

        // cfg_len 0 -> default length, abort at the first result.
        run(32'd0, 44100, 1, 1, 0, 0);
        idle_cycles(2, 1);

`ifdef INTERVAL_SCHED_WATCHDOG_EN
        begin
            exp_t s;
            cfg_len = 32'd2; start = 1; #2; sb_step(0, '0); @(posedge clk); #1; start = 0;
            sample_valid = 1; @(posedge clk); #1;
            #2; check("wd_ivl_end", mm_interval_done, 1); @(posedge clk); #1;
            sample_valid = 0;
            idle_cycles(1023, 0);
            #2; check("wd_no_early", wd_timeout, 0);
            s = {8'd0, 16'sh7FFF, 16'sh8000};
            sb_step(1, s);
            @(posedge clk); #1; #2;
            check("wd_timeout", wd_timeout, 1);
            check("wd_back_to_run", busy && !mm_interval_done, 1);
            @(posedge clk); #1;
            idle_cycles(3, 1);
            abort = 1; @(posedge clk); #1; abort = 0;
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/interval_scheduler.md
Name: interval_scheduler

Overview:
- Sequences the interval min/max datapath (min_max unit) for a programmable number of intervals.
- Counts accepted audio samples, gates them to the datapath and raises the end-of-interval strobe.
- Waits for the datapath result, then queues {index, min, max} in a result FIFO with a valid/ready read port.
- Sits between the sample source and the downstream statistics/filter stage.

Parameters:
- INTERVAL_LEN, 44100: default samples per interval; used when cfg_len is 0.
- NUM_INTERVALS, 10: intervals per run.
- FIFO_DEPTH, 16: result FIFO entries; power of two, at least 2.
- IDX_W, 8: width of the interval index.

Ports:
- clk  in  1  system clock (100 MHz)
- rst  in  1  asynchronous active-high reset
- start  in  1  begin a run; honoured in IDLE or DONE only
- abort  in  1  stop the run immediately
- cfg_len  in  32  samples per interval, latched on start; 0 selects INTERVAL_LEN
- sample_valid  in  1  source sample strobe
- mm_valid  out  1  sample strobe forwarded to min_max
- mm_interval_done  out  1  end-of-interval strobe to min_max
- mm_min  in  16 signed  min_max result, min
- mm_max  in  16 signed  min_max result, max
- mm_ready  in  1  min_max result valid, one-cycle pulse
- res_valid  out  1  FIFO not empty
- res_ready  in  1  consumer pop
- res_index  out  IDX_W  interval index of the FIFO head
- res_min  out  16 signed  FIFO head, min
- res_max  out  16 signed  FIFO head, max
- busy  out  1  state is RUN or WAIT_RES
- done  out  1  state is DONE
- overflow  out  1  sticky: a result was lost because the FIFO was full
- dropped  out  16  saturating count of samples arriving in WAIT_RES

Behaviour:
- Reset values: state IDLE; all counters 0; FIFO empty; all outputs 0.
- States and transitions:
  - IDLE: start -> RUN. On entry to RUN, len_q latches cfg_len (0 maps to INTERVAL_LEN); sample_cnt and interval_cnt clear.
  - RUN: mm_valid = sample_valid, combinational with zero latency. mm_interval_done = (sample_cnt == len_q-1), combinational.
    - sample_valid and not last: sample_cnt++.
    - sample_valid and last: sample_cnt <= 0; -> WAIT_RES.
  - WAIT_RES: mm_valid held 0; each sample_valid increments dropped, saturating at 0xFFFF.
    - On mm_ready: push {interval_cnt[IDX_W-1:0], mm_min, mm_max} and increment interval_cnt.
    - If the new interval_cnt equals NUM_INTERVALS -> DONE, else -> RUN.
    - A mm_ready seen in any other state is ignored.
  - DONE: done=1; start -> RUN (new run). FIFO contents are kept.
- abort in any state: -> IDLE next cycle, counters cleared, FIFO kept, no push that cycle. abort has priority over start and mm_ready.
- len_q = 1: every valid sample ends an interval (mm_interval_done is high for the whole of RUN).
- FIFO rules:
  - Push when full: data discarded, overflow set. overflow clears only on rst or start.
  - Push and pop in the same cycle when full: both succeed, no overflow.
  - Push and pop in the same cycle when empty: the push is stored, the pop has no effect.
  - res_ready while empty: ignored.
  - Outputs are first-word-fall-through: the res_* fields are valid whenever res_valid=1 and change one cycle after the pop.
- Index: interval_cnt is 32 bits; res_index carries its low IDX_W bits and wraps.
- Reset mid-run: immediate return to IDLE, FIFO flushed, min_max datapath is reset by the same rst.

Optional Feature:
- Macro: INTERVAL_SCHED_WATCHDOG_EN.
- Defined:
  - A 16-bit counter runs in WAIT_RES.
  - If 1024 cycles pass with no mm_ready: push {index, 16'sh7FFF, 16'sh8000} as a sentinel, set sticky output wd_timeout, and advance as if mm_ready had arrived.
  - wd_timeout clears on rst or start.
- Undefined: no counter; wd_timeout port absent; WAIT_RES waits indefinitely.

Decomposition:
- Package interval_pkg:
  - state enum IDLE/RUN/WAIT_RES/DONE;
  - result record {index, min, max};
  - watchdog limit 1024;
  - sentinel values.
- Sub-module result_fifo: parameterised depth and width, FWFT, full/empty flags, push/pop.

Test Plan:
- cfg_len=4, NUM_INTERVALS=3, continuous samples, mm_ready 2 cycles after each done -> mm_interval_done on samples 4, 8, 12; res_index 0, 1, 2; done=1; 2 samples dropped per interval (dropped=6).
- cfg_len=0 -> 44100 valid samples precede the first mm_interval_done; len_q=44100.
- FIFO_DEPTH=2, res_ready=0, 3 intervals -> 2 entries held, overflow=1; the third pops with res_ready held 1 at the moment of push -> no overflow.
- abort in WAIT_RES with mm_ready on the same cycle -> IDLE, no push, FIFO count unchanged.
- cfg_len=1 -> every sample raises mm_interval_done; interval_cnt advances once per mm_ready.
- INTERVAL_SCHED_WATCHDOG_EN defined, mm_ready withheld -> after 1024 cycles a sentinel 32767/-32768 is pushed, wd_timeout=1, state returns to RUN.
